seg_scan_mux: RTL and testbench



---
 rtl/seg_scan_mux_if.sv | 23 ++
 rtl/seg_scan_mux.sv | 68 ++++++
 tb/tb_seg_scan_mux.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seg_scan_mux_if.sv
// Digit data/mask in, segment/anode drive and frame pulse out, for the N-digit scanner.
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [NUM_DIGITS*8-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   digit_mask;
    logic [7:0]              seg_out;
    logic [NUM_DIGITS-1:0]   seg_enable;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_tick;

    modport master (
        output digits_in, digit_mask,
        input  seg_out, seg_enable, digit_idx, frame_tick
    );

    modport slave (
        input  digits_in, digit_mask,
        output seg_out, seg_enable, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// N-digit seven-segment scanner with mask skip, per-slot blanking and tear-free latching.
// Latency: pattern latched at slot cycle BLANK, shown the same cycle; no backpressure (free-running scan).
module seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int PERIOD     = 10_000,
    parameter int BLANK      = 64
) (
    input  logic          clk,
    input  logic          rst,
    seg_scan_mux_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [15:0]      cnt;
    logic [IDX_W-1:0] idx;
    logic [7:0]       lat;

    logic             slot_end;
    logic             show;
    logic             hi_found;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;
    logic [IDX_W-1:0] next_idx;

    assign slot_end = (cnt == 16'(PERIOD - 1));

    // Descending scan: the last hit is the smallest enabled index, above idx or overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            if (bus.digit_mask[j]) begin
                lo_idx = IDX_W'(j);
                if (j > int'(idx)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(j);
                end
            end
        end
        next_idx = hi_found ? hi_idx : lo_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
            lat <= 8'h00;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= next_idx;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (cnt == 16'(BLANK - 1)) begin
                lat <= bus.digits_in[{idx, 3'b000} +: 8];
            end
        end
    end

    assign show = (cnt >= 16'(BLANK)) && bus.digit_mask[idx];

    assign bus.seg_out    = show ? lat : 8'h00;
    assign bus.seg_enable = show ? ~(NUM_DIGITS'(1) << idx) : {NUM_DIGITS{1'b1}};
    assign bus.digit_idx  = idx;
    assign bus.frame_tick = slot_end && (next_idx <= idx);
endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux with NUM_DIGITS=4, PERIOD=20, BLANK=4.
module tb_seg_scan_mux;
    localparam int ND  = 4;
    localparam int PER = 20;
    localparam int BLK = 4;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] en;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    exp_t sb_q[$];
    logic [7:0] pats[4];

    seg_scan_mux_if #(.NUM_DIGITS(ND)) dut_if ();

    seg_scan_mux #(.NUM_DIGITS(ND), .PERIOD(PER), .BLANK(BLK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Pushes the expected outputs for this cycle, compares at the falling edge,
    // then returns just after the next rising edge, ready for the next cycle's stimulus.
    task automatic cycle_chk(input string tag, input int p, input int d, input bit sh,
                             input logic [7:0] pat, input bit tick);
        exp_t e;
        exp_t got;
        e.seg  = (p >= BLK && sh) ? pat : 8'h00;
        e.en   = (p >= BLK && sh) ? ~(4'b0001 << d) : 4'b1111;
        e.idx  = 2'(d);
        e.tick = tick;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        chk({tag, ".seg"},  32'(dut_if.seg_out),    32'(got.seg));
        chk({tag, ".en"},   32'(dut_if.seg_enable), 32'(got.en));
        chk({tag, ".idx"},  32'(dut_if.digit_idx),  32'(got.idx));
        chk({tag, ".tick"}, 32'(dut_if.frame_tick), 32'(got.tick));
        @(posedge clk);
        #1;
    endtask

    // Holds rst for n edges; outputs after all but the last edge are checked as reset state,
    // the cycle after the last edge is cycle 0 of the following scan.
    task automatic do_reset(input int n);
        exp_t e;
        exp_t got;
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i < n - 1) begin
                e.seg = 8'h00; e.en = 4'b1111; e.idx = 2'd0; e.tick = 1'b0;
                sb_q.push_back(e);
                @(negedge clk);
                got = sb_q.pop_front();
                chk("rst.seg",  32'(dut_if.seg_out),    32'(got.seg));
                chk("rst.en",   32'(dut_if.seg_enable), 32'(got.en));
                chk("rst.idx",  32'(dut_if.digit_idx),  32'(got.idx));
                chk("rst.tick", 32'(dut_if.frame_tick), 32'(got.tick));
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        int s;
        int p;
        int d;
        logic [7:0] pat;

        n_chk = 0;
        n_err = 0;
        pats = '{8'h3F, 8'h06, 8'h5B, 8'h4F};
        rst = 1'b1;
        dut_if.digits_in  = {8'h4F, 8'h5B, 8'h06, 8'h3F};
        dut_if.digit_mask = 4'b1111;

        do_reset(3);

        // Full rotation up to cycle 49, then a one-cycle reset at cycle 50.
        for (int c = 0; c < 50; c++) begin
            s = c / PER; p = c % PER; d = s % ND;
            cycle_chk("rot", p, d, 1'b1, pats[d], (c % 80) == 79);
        end
        rst = 1'b1;
        cycle_chk("rot50", 50 % PER, (50 / PER) % ND, 1'b1, pats[(50 / PER) % ND], 1'b0);
        rst = 1'b0;

        // Restarted scan; digit 0 changes at cycle 10 and only shows from cycle 84.
        for (int c = 0; c < 170; c++) begin
            if (c == 10) dut_if.digits_in[7:0] = 8'h7F;
            s = c / PER; p = c % PER; d = s % ND;
            pat = (d == 0 && c >= 80) ? 8'h7F : pats[d];
            cycle_chk("tear", p, d, 1'b1, pat, (c % 80) == 79);
        end

        // Masked skip: only digits 0 and 2.
        dut_if.digits_in  = {8'h4F, 8'h5B, 8'h06, 8'h3F};
        dut_if.digit_mask = 4'b0101;
        do_reset(1);
        for (int c = 0; c < 120; c++) begin
            s = c / PER; p = c % PER; d = (s % 2 == 1) ? 2 : 0;
            cycle_chk("skip", p, d, 1'b1, pats[d], (c % 40) == 39);
        end

        // Empty mask, then digit 1 enabled mid-slot at cycle 65.
        dut_if.digit_mask = 4'b0000;
        do_reset(1);
        for (int c = 0; c < 120; c++) begin
            if (c == 65) dut_if.digit_mask = 4'b0010;
            p = c % PER;
            if (c < 80)
                cycle_chk("empty", p, 0, 1'b0, 8'h00, (p == PER - 1) && (c != 79));
            else
                cycle_chk("enable", p, 1, 1'b1, pats[1], p == PER - 1);
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
